// File: rtl/micro_core.sv
// -----------------------------------------------------------------------------
// micro_core
//   A small multi-cycle accumulator-style core. It accepts one instruction at a
//   time through a valid/ready handshake, sequences it through
//   FETCH -> EXEC -> (MEM) -> WB, and owns a register file, an internal data
//   memory (synchronous read, no reset) and an output port register.
//
// Parameters
//   DATA_W    : width of registers, memory words, ALU and out
//   NREG      : register-file entries (power of 2, >= 2)
//   MEM_DEPTH : data-memory words (power of 2)
//
// Ports
//   clk         in   single clock, all state changes on rising edge
//   rst         in   synchronous active-high reset
//   instr       in   instruction word {opcode[3:0], rd, rs/imm}
//   instr_valid in   instr is valid this cycle
//   instr_ready out  high only in FETCH
//   out         out  output port register (written by OUT)
//   out_valid   out  one-cycle pulse after an OUT write-back
//   carry_flag  out  carry (SUM) / borrow (SMI)
//   zero_flag   out  result of last SUM/SMI was zero
// -----------------------------------------------------------------------------
module micro_core #(
    parameter int DATA_W    = 8,
    parameter int NREG      = 4,
    parameter int MEM_DEPTH = 16,
    localparam int RSEL_W   = $clog2(NREG),
    localparam int AW       = $clog2(MEM_DEPTH),
    localparam int INSTR_W  = 4 + 2 * RSEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  out,
    output logic               out_valid,
    output logic               carry_flag,
    output logic               zero_flag
);

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_MR  = 4'b0011;
    localparam logic [3:0] OP_SUM = 4'b0100;
    localparam logic [3:0] OP_SMI = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b0101;
    localparam logic [3:0] OP_LDI = 4'b0110;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [INSTR_W-1:0] ir_q;
    logic [DATA_W-1:0]  regs_q [NREG];
    logic [DATA_W-1:0]  mem_q  [MEM_DEPTH];
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  out_q;
    logic               out_valid_q;
    logic               carry_q;
    logic               zero_q;

    // Instruction fields decoded from the latched IR
    logic [3:0]        ir_op;
    logic [RSEL_W-1:0] ir_rd;
    logic [RSEL_W-1:0] ir_rs;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] imm_ext;
    logic [AW-1:0]     mem_addr;

    assign ir_op    = ir_q[INSTR_W-1 -: 4];
    assign ir_rd    = ir_q[2*RSEL_W-1 -: RSEL_W];
    assign ir_rs    = ir_q[RSEL_W-1:0];
    assign rd_val   = regs_q[ir_rd];
    assign rs_val   = regs_q[ir_rs];
    assign imm_ext  = {{(DATA_W-RSEL_W){1'b0}}, ir_rs};
    // High address bits are dropped so addresses wrap modulo MEM_DEPTH
    assign mem_addr = rs_val[AW-1:0];

    // FSM control strobes
    logic accept;
    logic mem_we;
    logic mem_re;
    logic wb_en;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (accept) state_d = S_EXEC;
            S_EXEC: begin
                if (ir_op == OP_LD)      state_d = S_MEM;
                else if (ir_op == OP_ST) state_d = S_FETCH;
                else                     state_d = S_WB;
            end
            S_MEM:   state_d = S_WB;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = (state_q == S_FETCH);
        accept      = instr_ready && instr_valid;
        mem_we      = (state_q == S_EXEC) && (ir_op == OP_ST);
        mem_re      = (state_q == S_MEM);
        wb_en       = (state_q == S_WB);
    end

    // ------------------------------------------------------------------
    // Write-back datapath: ALU and write enables
    // ------------------------------------------------------------------
    logic [DATA_W:0]   alu;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              flag_we;
    logic              out_we;

    always_comb begin
        alu       = '0;
        reg_we    = 1'b0;
        reg_wdata = '0;
        flag_we   = 1'b0;
        out_we    = 1'b0;

        // Bit DATA_W is carry-out for SUM and the borrow for SMI
        case (ir_op)
            OP_SUM:  alu = {1'b0, rd_val} + {1'b0, rs_val};
            OP_SMI:  alu = {1'b0, rd_val} - {1'b0, imm_ext};
            default: alu = '0;
        endcase

        if (wb_en) begin
            case (ir_op)
                OP_LD: begin
                    reg_we    = 1'b1;
                    reg_wdata = rdata_q;
                end
                OP_MR: begin
                    reg_we    = 1'b1;
                    reg_wdata = rs_val;
                end
                OP_SUM, OP_SMI: begin
                    reg_we    = 1'b1;
                    reg_wdata = alu[DATA_W-1:0];
                    flag_we   = 1'b1;
                end
                OP_OUT: out_we = 1'b1;
                OP_LDI: begin
                    reg_we    = 1'b1;
                    reg_wdata = imm_ext;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file: one flop bank per entry
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else if (reg_we && (ir_rd == RSEL_W'(gi))) begin
                    regs_q[gi] <= reg_wdata;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // IR, flags and output port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_we;
            if (accept) begin
                ir_q <= instr;
            end
            if (out_we) begin
                out_q <= rd_val;
            end
            if (flag_we) begin
                carry_q <= alu[DATA_W];
                zero_q  <= (alu[DATA_W-1:0] == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Data memory: contents survive reset; reset only blocks the write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_addr] <= rd_val;
        end
        if (mem_re) begin
            rdata_q <= mem_q[mem_addr];
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule

// File: tb/tb_micro_core.sv
// -----------------------------------------------------------------------------
// tb_micro_core
//   Self-checking bench for micro_core. A default-parameter instance runs
//   directed programs and a random program against a behavioural model; a
//   second instance (DATA_W=16, NREG=8, MEM_DEPTH=32) runs a short directed
//   sequence.
// -----------------------------------------------------------------------------
module tb_micro_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       carry_flag;
    logic       zero_flag;

    logic [9:0]  b_instr;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] b_out;
    logic        b_out_valid;
    logic        b_carry;
    logic        b_zero;

    always #5 clk = ~clk;

    micro_core dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .out         (out),
        .out_valid   (out_valid),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag)
    );

    micro_core #(.DATA_W(16), .NREG(8), .MEM_DEPTH(32)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .instr       (b_instr),
        .instr_valid (b_valid),
        .instr_ready (b_ready),
        .out         (b_out),
        .out_valid   (b_out_valid),
        .carry_flag  (b_carry),
        .zero_flag   (b_zero)
    );

    localparam logic [3:0] LD = 4'b0000, ST = 4'b0001, MR = 4'b0011, SUM = 4'b0100;
    localparam logic [3:0] SMI = 4'b1100, OUTP = 4'b0101, LDI = 4'b0110;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (plain integers)
    int m_reg [4];
    int m_mem [16];
    int m_c, m_z, m_out;

    function automatic logic [7:0] enc(input logic [3:0] op, input int rd, input int rs);
        enc = {op, 2'(rd), 2'(rs)};
    endfunction

    function automatic logic [9:0] enc_b(input logic [3:0] op, input int rd, input int rs);
        enc_b = {op, 3'(rd), 3'(rs)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_c = 0; m_z = 0; m_out = 0;
    endtask

    task automatic model_step(input logic [7:0] ins);
        int op, rd, rs, a, b, s;
        op = int'(ins[7:4]); rd = int'(ins[3:2]); rs = int'(ins[1:0]);
        a = m_reg[rd]; b = m_reg[rs];
        case (op)
            0:  m_reg[rd] = m_mem[b % 16];
            1:  m_mem[b % 16] = a;
            3:  m_reg[rd] = b;
            4: begin
                s = a + b;
                m_reg[rd] = s % 256; m_c = (s > 255) ? 1 : 0; m_z = (s % 256 == 0) ? 1 : 0;
            end
            12: begin
                s = (a - rs + 256) % 256;
                m_reg[rd] = s; m_c = (rs > a) ? 1 : 0; m_z = (s == 0) ? 1 : 0;
            end
            5:  m_out = a;
            6:  m_reg[rd] = rs;
            default: ;
        endcase
    endtask

    // Issue one instruction with valid held; junk is driven while busy and
    // must be ignored. Returns with the core back in FETCH, 1 time unit
    // after the re-entry edge.
    task automatic exec(input logic [7:0] ins);
        int cyc, exp_lat;
        logic [3:0] op;
        op = ins[7:4];
        exp_lat = (op == ST) ? 2 : (op == LD) ? 4 : 3;
        instr = ins; instr_valid = 1'b1;
        @(posedge clk); #1;
        chk("ready_low_after_accept", instr_ready, 0);
        chk("out_valid_one_cycle", out_valid, 0);
        model_step(ins);
        cyc = 1;
        while (instr_ready !== 1'b1 && cyc < 8) begin
            instr = 8'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        instr_valid = 1'b0;
        $display("exec %02h op=%b lat=%0d out=%02h ov=%b C=%b Z=%b", ins, op, cyc, out, out_valid, carry_flag, zero_flag);
        chk("latency", cyc, exp_lat);
        chk("out_valid", out_valid, (op == OUTP) ? 1 : 0);
        chk("out", out, m_out);
        chk("carry", carry_flag, m_c);
        chk("zero", zero_flag, m_z);
    endtask

    task automatic exec_b(input logic [9:0] ins);
        int cyc;
        b_instr = ins; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        cyc = 1;
        while (b_ready !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("exec_b %03h lat=%0d out=%04h ov=%b C=%b Z=%b", ins, cyc, b_out, b_out_valid, b_carry, b_zero);
        chk("b_ready_back", b_ready, 1);
    endtask

    // Reset for one edge; optionally with a valid instruction presented
    task automatic do_reset(input logic with_valid);
        rst = 1'b1;
        instr = enc(LDI, 1, 3);
        instr_valid = with_valid;
        @(posedge clk); #1;
        rst = 1'b0; instr_valid = 1'b0;
        model_reset();
        $display("reset with_valid=%b", with_valid);
    endtask

    task automatic chk_idle_reset_state(input string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_out"}, out, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_carry"}, carry_flag, 0);
        chk({tag, "_zero"}, zero_flag, 0);
    endtask

    int nop_ops [9] = '{2, 7, 8, 9, 10, 11, 13, 14, 15};

    initial begin
        int k, rd, rs;
        logic [3:0] op;
        rst = 1'b1; instr = '0; instr_valid = 1'b0;
        b_instr = '0; b_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk_idle_reset_state("reset");
        chk("b_reset_ready", b_ready, 1);
        chk("b_reset_out", b_out, 0);

        // Fill data memory so every later LD has a defined value
        exec(enc(LDI, 2, 1));
        exec(enc(LDI, 0, 0));
        for (int a = 0; a < 16; a++) begin
            exec(enc(LDI, 1, int'($urandom_range(0, 3))));
            exec(enc(ST, 1, 0));
            exec(enc(SUM, 0, 2));
        end

        // Basic ALU program
        do_reset(1'b0);
        exec(enc(LDI, 1, 3));
        exec(enc(LDI, 2, 2));
        exec(enc(SUM, 1, 2));
        exec(enc(OUTP, 1, 0));
        chk("basic_out", out, 8'd5);
        chk("basic_c", carry_flag, 0);
        chk("basic_z", zero_flag, 0);

        // Carry / borrow / wrap
        exec(enc(LDI, 1, 3));
        exec(enc(SMI, 1, 3));
        chk("smi_zero_z", zero_flag, 1);
        chk("smi_zero_c", carry_flag, 0);
        exec(enc(SMI, 1, 1));
        chk("smi_borrow_c", carry_flag, 1);
        chk("smi_borrow_z", zero_flag, 0);
        exec(enc(OUTP, 1, 0));
        chk("smi_borrow_val", out, 8'd255);
        exec(enc(SUM, 1, 1));
        exec(enc(OUTP, 1, 0));
        chk("sum_self_val", out, 8'd254);
        chk("sum_self_c", carry_flag, 1);

        // Memory and address aliasing
        exec(enc(LDI, 0, 2));
        exec(enc(LDI, 3, 1));
        exec(enc(ST, 3, 0));
        exec(enc(LD, 2, 0));
        exec(enc(OUTP, 2, 0));
        chk("mem_ld_val", out, 8'd1);
        exec(enc(LDI, 0, 3));
        exec(enc(SUM, 0, 0));
        exec(enc(SUM, 0, 0));
        exec(enc(LDI, 1, 3));
        exec(enc(SUM, 0, 1));
        exec(enc(SUM, 0, 1));
        exec(enc(OUTP, 0, 0));
        chk("alias_addr", out, 8'd18);
        exec(enc(LDI, 2, 0));
        exec(enc(LD, 2, 0));
        exec(enc(OUTP, 2, 0));
        chk("alias_word2", out, 8'd1);

        // Wide instance
        exec_b(enc_b(LDI, 7, 7));
        exec_b(enc_b(SMI, 7, 7));
        chk("b_smi_z", b_zero, 1);
        chk("b_smi_c", b_carry, 0);
        exec_b(enc_b(LDI, 1, 0));
        exec_b(enc_b(SMI, 1, 1));
        chk("b_borrow_c", b_carry, 1);
        chk("b_borrow_z", b_zero, 0);
        exec_b(enc_b(OUTP, 1, 0));
        chk("b_out_ffff", b_out, 16'hFFFF);
        chk("b_out_valid", b_out_valid, 1);
        exec_b(enc_b(LDI, 2, 1));
        exec_b(enc_b(SUM, 1, 2));
        chk("b_wrap_c", b_carry, 1);
        chk("b_wrap_z", b_zero, 1);
        exec_b(enc_b(OUTP, 1, 0));
        chk("b_wrap_out", b_out, 16'h0000);

        // Reset during MEM of an LD; out and flags made nonzero first
        exec(enc(LDI, 1, 3));
        exec(enc(SMI, 1, 3));
        exec(enc(OUTP, 1, 0));
        exec(enc(LDI, 3, 3));
        exec(enc(OUTP, 3, 0));
        exec(enc(LDI, 0, 2));
        instr = enc(LD, 2, 0); instr_valid = 1'b1;
        @(posedge clk); #1;          // EXEC
        instr_valid = 1'b0;
        @(posedge clk); #1;          // MEM
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        $display("reset during MEM of LD r2");
        chk_idle_reset_state("midop");
        exec(enc(OUTP, 2, 0));
        chk("midop_r2", out, 0);

        // Reset wins over a simultaneous valid instruction
        exec(enc(LDI, 3, 2));
        do_reset(1'b1);
        chk_idle_reset_state("rst_prio");
        exec(enc(OUTP, 1, 0));
        exec(enc(OUTP, 3, 0));

        // Random program
        for (int n = 0; n < 300; n++) begin
            k  = int'($urandom_range(0, 7));
            rd = int'($urandom_range(0, 3));
            rs = int'($urandom_range(0, 3));
            case (k)
                0: op = LD;
                1: op = ST;
                2: op = MR;
                3: op = SUM;
                4: op = SMI;
                5: op = OUTP;
                6: op = LDI;
                default: op = 4'(nop_ops[$urandom_range(0, 8)]);
            endcase
            exec(enc(op, rd, rs));
            if ($urandom_range(0, 1) == 1) exec(enc(OUTP, rd, 0));
        end

        instr_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/micro_core.md
MICRO_CORE -- requirements
Module: micro_core

Interface
REQ-001 Parameter DATA_W, default 8: width of registers, memory words, ALU and out.
REQ-002 Parameter NREG, default 4, power of 2 >= 2: register-file entries; RSEL_W = log2(NREG).
REQ-003 Parameter MEM_DEPTH, default 16, power of 2: internal data memory words; AW = log2(MEM_DEPTH).
REQ-004 Derived: INSTR_W = 4 + 2*RSEL_W; opcode = instr[INSTR_W-1 -: 4], rd = next RSEL_W bits, rs/imm = low RSEL_W bits.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 instr  input  INSTR_W  instruction word.
REQ-008 instr_valid  input  1  instr is valid this cycle.
REQ-009 instr_ready  output  1  core can accept an instruction this cycle.
REQ-010 out  output  DATA_W  output port register.
REQ-011 out_valid  output  1  one-cycle pulse: out updated by OUT.
REQ-012 carry_flag  output  1  carry/borrow flag.
REQ-013 zero_flag  output  1  zero flag.

Function
REQ-014 Opcodes SHALL be: 0000 LD rd <- mem[reg[rs][AW-1:0]]; 0001 ST mem[reg[rs][AW-1:0]] <- reg[rd]; 0011 MR rd <- reg[rs]; 0100 SUM rd <- reg[rd]+reg[rs]; 1100 SMI rd <- reg[rd] - zero-extended imm; 0101 OUT out <- reg[rd]; 0110 LDI rd <- zero-extended imm; all others NOP.
REQ-015 FSM states SHALL be FETCH, EXEC, MEM, WB; reset state FETCH.
REQ-016 instr_ready SHALL be 1 only in FETCH; an instruction is accepted when instr_valid && instr_ready at a rising edge and latched into an internal IR.
REQ-017 FETCH -> EXEC on accept; otherwise stay in FETCH.
REQ-018 EXEC: LD -> MEM; ST writes memory then -> FETCH; all other ops -> WB.
REQ-019 MEM: memory read captured (synchronous read) -> WB.
REQ-020 WB: register/out/flag write-back performed -> FETCH.
REQ-021 Latency: ST 2 cycles accept-to-FETCH; MR/SUM/SMI/OUT/LDI/NOP 3 cycles; LD 4 cycles; result visible in reg file on the cycle the FSM re-enters FETCH.
REQ-022 SUM/SMI arithmetic SHALL be DATA_W+1 bits; result = low DATA_W bits; SUM carry = bit DATA_W (carry-out); SMI carry = 1 on borrow (imm > reg[rd]).
REQ-023 zero_flag = (result == 0); flags updated only by SUM and SMI, held otherwise.
REQ-024 Addresses SHALL wrap modulo MEM_DEPTH (high register bits ignored).
REQ-025 rd == rs SHALL use the pre-instruction value for both operands (SUM r1,r1 doubles r1).
REQ-026 out_valid SHALL pulse high exactly one cycle, in the cycle after the OUT write-back edge; out holds between OUTs.
REQ-027 instr_valid while not in FETCH SHALL be ignored; no queuing.

Reset
REQ-028 On rst at a rising edge: state FETCH, all registers 0, IR 0, out 0, out_valid 0, carry_flag 0, zero_flag 0; memory contents undefined-but-unchanged (not cleared).
REQ-029 rst SHALL abort any in-flight instruction with no register, memory, flag or out write; instr_ready = 1 in the first cycle after reset.
REQ-030 rst takes priority over instr_valid in the same cycle.

Verification
REQ-031 Defaults: LDI r1,3; LDI r2,2; SUM r1,r2; OUT r1 -> out=5, out_valid one pulse, C=0, Z=0; each ALU op 3 cycles.
REQ-032 Carry/wrap: LDI r1,3; SMI r1,3 -> r1=0, Z=1, C=0; SMI r1,1 -> r1=255, C=1, Z=0; then SUM r1,r1 -> r1=254, C=1.
REQ-033 Memory: LDI r0,2; LDI r3,1; ST r3,[r0]; LD r2,[r0]; OUT r2 -> out=1; LD takes 4 cycles; address 18 (if reg holds 18) aliases word 2.
REQ-034 Handshake: hold instr_valid high continuously with distinct instructions -> each accepted only when instr_ready=1, none dropped or duplicated, ready low in EXEC/MEM/WB.
REQ-035 Reset mid-op: assert rst during MEM of LD r2 -> r2 stays 0, out/flags 0, instr_ready=1 next cycle.
REQ-036 Parameter sweep: DATA_W=16, NREG=8, MEM_DEPTH=32 -> INSTR_W=10; LDI r7,7; SMI r7,7 -> Z=1; SUM over 0xFFFF+1 -> result 0, C=1, Z=1.
